bcd_key_entry: RTL and testbench

- Input-side counterpart of the adder/display path. The display path turns a binary result into BCD digits for the seven-segment display; this block works the other way.
- The operator keys in up to two decimal digits from the 4-bit switches using debounced keys. On "enter", the block converts the two-digit BCD number to binary with a sequential reverse double-dabble.
- The 7-bit binary value (0..99) is handed to downstream arithmetic over a valid/ready handshake.
- The entered digits are exported for the seven-segment display.

---
 rtl/bcd_key_entry.sv | 132 +++++++++++++
 tb/tb_bcd_key_entry.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_key_entry.sv
// Two-digit BCD keypad entry with sequential reverse double-dabble conversion
// to a 7-bit binary value, presented downstream over a valid/ready handshake.
module bcd_key_entry (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_dig,
    input  logic       key_dig,
    input  logic       key_ent,
    input  logic       key_clr,
    output logic [6:0] bin_out,
    output logic       bin_valid,
    input  logic       bin_ready,
    output logic [3:0] dig_tens,
    output logic [3:0] dig_ones,
    output logic       busy,
    output logic       err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [2:0]  key_q;
    logic [2:0]  press_q;
    logic [15:0] work;
    logic [15:0] shifted;
    logic [15:0] work_next;
    logic [3:0]  cnt;
    logic        clr_p;
    logic        ent_p;
    logic        dig_p;

    // Falling edges of the active-low keys are captured as one-cycle pulses;
    // the FSM acts on these registered pulses one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q   <= 3'b111;
            press_q <= 3'b000;
        end else begin
            key_q   <= {key_clr, key_ent, key_dig};
            press_q <= ~{key_clr, key_ent, key_dig} & key_q;
        end
    end

    assign clr_p = press_q[2];
    assign ent_p = press_q[1] & ~press_q[2];
    assign dig_p = press_q[0] & ~press_q[1] & ~press_q[2];

    // One reverse double-dabble step: shift right, then pull each BCD nibble
    // of the upper byte back by 3 where it reached 8 or more.
    always_comb begin
        shifted   = work >> 1;
        work_next = shifted;
        if (shifted[15:12] >= 4'd8) begin
            work_next[15:12] = shifted[15:12] - 4'd3;
        end
        if (shifted[11:8] >= 4'd8) begin
            work_next[11:8] = shifted[11:8] - 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dig_tens  <= 4'd0;
            dig_ones  <= 4'd0;
            bin_out   <= 7'd0;
            bin_valid <= 1'b0;
            err       <= 1'b0;
            work      <= 16'd0;
            cnt       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_p) begin
                        dig_tens <= 4'd0;
                        dig_ones <= 4'd0;
                        err      <= 1'b0;
                    end else if (ent_p) begin
                        work  <= {dig_tens, dig_ones, 8'h00};
                        cnt   <= 4'd0;
                        state <= CONV;
                    end else if (dig_p) begin
                        if (sw_dig <= 4'd9) begin
                            dig_tens <= dig_ones;
                            dig_ones <= sw_dig;
                            err      <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    if (clr_p) begin
                        dig_tens <= 4'd0;
                        dig_ones <= 4'd0;
                        err      <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        work <= work_next;
                        cnt  <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            bin_out   <= work_next[6:0];
                            bin_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (clr_p) begin
                        dig_tens  <= 4'd0;
                        dig_ones  <= 4'd0;
                        err       <= 1'b0;
                        bin_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (bin_ready) begin
                        bin_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bin_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == CONV) || (state == HOLD);

endmodule

// File: tb/tb_bcd_key_entry.sv
// Directed self-checking bench for bcd_key_entry: digit entry, conversion
// results, handshake timing, error flag, abort, reset and key priority.
module tb_bcd_key_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] swDig = 4'd0;
    logic       keyDig = 1'b1;
    logic       keyEnt = 1'b1;
    logic       keyClr = 1'b1;
    logic [6:0] binOut;
    logic       binValid;
    logic       binReady = 1'b0;
    logic [3:0] digTens;
    logic [3:0] digOnes;
    logic       busy;
    logic       err;

    int totalCount = 0;
    int badCount = 0;

    int busyCnt;
    int validCnt;
    int value;
    int unstable;
    int everValid;

    bcd_key_entry dut (
        .clk       (clk),
        .rst       (rst),
        .sw_dig    (swDig),
        .key_dig   (keyDig),
        .key_ent   (keyEnt),
        .key_clr   (keyClr),
        .bin_out   (binOut),
        .bin_valid (binValid),
        .bin_ready (binReady),
        .dig_tens  (digTens),
        .dig_ones  (digOnes),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    // which: 0 = digit, 1 = enter, 2 = clear
    task automatic applyStimulus(input int which, input logic [3:0] d);
        @(negedge clk);
        swDig = d;
        if (which == 0) keyDig = 1'b0;
        if (which == 1) keyEnt = 1'b0;
        if (which == 2) keyClr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        keyDig = 1'b1;
        keyEnt = 1'b1;
        keyClr = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic entAndCollect(input int readyDelay, input bit withDig, input bit holdDig,
                                 output int bCnt, output int vCnt, output int val, output int unst);
        bit done;
        bCnt = 0;
        vCnt = 0;
        val  = -1;
        unst = 0;
        done = 1'b0;
        @(negedge clk);
        keyEnt = 1'b0;
        if (withDig) keyDig = 1'b0;
        binReady = (readyDelay == 0);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            keyEnt = 1'b1;
            if (withDig) keyDig = 1'b1;
            if (holdDig && i == 2) keyDig = 1'b0;
            if (busy) bCnt++;
            if (binValid) begin
                if (vCnt > 0 && int'(binOut) != val) unst = 1;
                val = int'(binOut);
                vCnt++;
                if (vCnt == readyDelay) binReady = 1'b1;
            end
            if (vCnt > 0 && !busy) done = 1'b1;
        end
        checkOutput("conv_done", int'(done), 1);
        binReady = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        #12;
        checkOutput("rst_tens", digTens, 0);
        checkOutput("rst_ones", digOnes, 0);
        checkOutput("rst_bin", binOut, 0);
        checkOutput("rst_valid", binValid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 4, 7, enter with ready already high
        applyStimulus(0, 4'd4);
        applyStimulus(0, 4'd7);
        checkOutput("t1_tens", digTens, 4);
        checkOutput("t1_ones", digOnes, 7);
        entAndCollect(0, 1'b0, 1'b0, busyCnt, validCnt, value, unstable);
        checkOutput("t1_busy_cycles", busyCnt, 9);
        checkOutput("t1_valid_cycles", validCnt, 1);
        checkOutput("t1_value", value, 47);
        checkOutput("t1_keep_tens", digTens, 4);
        checkOutput("t1_keep_ones", digOnes, 7);

        // 9, 9, enter with ready held off for 20 valid cycles
        applyStimulus(0, 4'd9);
        applyStimulus(0, 4'd9);
        entAndCollect(20, 1'b0, 1'b0, busyCnt, validCnt, value, unstable);
        checkOutput("t2_value", value, 99);
        checkOutput("t2_valid_cycles", validCnt, 20);
        checkOutput("t2_busy_cycles", busyCnt, 28);
        checkOutput("t2_stable", unstable, 0);
        checkOutput("t2_valid_after", binValid, 0);

        // single digit, three digits, and empty entry
        applyStimulus(2, 4'd0);
        applyStimulus(0, 4'd5);
        entAndCollect(0, 1'b0, 1'b0, busyCnt, validCnt, value, unstable);
        checkOutput("t3_single", value, 5);
        applyStimulus(0, 4'd1);
        applyStimulus(0, 4'd2);
        applyStimulus(0, 4'd3);
        checkOutput("t3_shift_tens", digTens, 2);
        checkOutput("t3_shift_ones", digOnes, 3);
        entAndCollect(0, 1'b0, 1'b0, busyCnt, validCnt, value, unstable);
        checkOutput("t3_three", value, 23);
        applyStimulus(2, 4'd0);
        checkOutput("t3_clr_tens", digTens, 0);
        checkOutput("t3_clr_ones", digOnes, 0);
        entAndCollect(0, 1'b0, 1'b0, busyCnt, validCnt, value, unstable);
        checkOutput("t3_zero", value, 0);

        // rejected digit then an accepted one
        applyStimulus(0, 4'd6);
        applyStimulus(0, 4'd12);
        checkOutput("t4_err_set", err, 1);
        checkOutput("t4_rej_tens", digTens, 0);
        checkOutput("t4_rej_ones", digOnes, 6);
        applyStimulus(0, 4'd3);
        checkOutput("t4_err_clr", err, 0);
        checkOutput("t4_tens", digTens, 6);
        checkOutput("t4_ones", digOnes, 3);
        applyStimulus(0, 4'd15);
        entAndCollect(0, 1'b0, 1'b0, busyCnt, validCnt, value, unstable);
        checkOutput("t4_ent_keeps_err", err, 1);
        checkOutput("t4_value", value, 63);

        // clear aborts a running conversion
        applyStimulus(2, 4'd0);
        applyStimulus(0, 4'd8);
        applyStimulus(0, 4'd1);
        everValid = 0;
        @(negedge clk);
        keyEnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            keyEnt = 1'b1;
            if (binValid) everValid = 1;
        end
        keyClr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            keyClr = 1'b1;
            if (binValid) everValid = 1;
        end
        checkOutput("t5_abort_valid", everValid, 0);
        checkOutput("t5_abort_busy", busy, 0);
        checkOutput("t5_abort_tens", digTens, 0);
        checkOutput("t5_abort_ones", digOnes, 0);

        // reset pulse during a conversion
        applyStimulus(0, 4'd8);
        applyStimulus(0, 4'd1);
        @(negedge clk);
        keyEnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            keyEnt = 1'b1;
        end
        checkOutput("t5_busy_before_rst", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_valid", binValid, 0);
        checkOutput("t5_rst_bin", binOut, 0);
        checkOutput("t5_rst_tens", digTens, 0);
        checkOutput("t5_rst_ones", digOnes, 0);
        checkOutput("t5_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // enter and digit in the same cycle: enter wins
        applyStimulus(0, 4'd5);
        swDig = 4'd7;
        entAndCollect(0, 1'b1, 1'b0, busyCnt, validCnt, value, unstable);
        checkOutput("t6_value", value, 5);
        checkOutput("t6_tens", digTens, 0);
        checkOutput("t6_ones", digOnes, 5);

        // digit key held through the conversion never re-triggers
        swDig = 4'd2;
        entAndCollect(0, 1'b0, 1'b1, busyCnt, validCnt, value, unstable);
        checkOutput("t7_value", value, 5);
        repeat (5) @(negedge clk);
        checkOutput("t7_tens", digTens, 0);
        checkOutput("t7_ones", digOnes, 5);
        keyDig = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
